multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Multi-cycle control FSM for the CPU datapath. It sequences one instruction at a time through fetch, decode, execute, memory and write-back. It drives every datapath enable and mux select, and generates `alu_func` from the instruction's opcode/funct fields. It sits between the instruction register and the shared instruction/data memory port, and owns the only memory request line in the core.

## Interface
Parameters:
- `MEM_TIMEOUT`, 255: maximum cycles a memory request may wait for `mem_ready` before the FSM enters ERR (1..255).

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `inst` in 32: current instruction register contents.
- `alu_zero` in 1: ALU result == 0.
- `mem_ready` in 1: memory completes the request this cycle; ignored while `mem_req`=0.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: request is a store.
- `mem_sel` out 1: 0 = address is PC (fetch), 1 = address is ALU result (data).
- `ir_we` out 1: load instruction register.
- `pc_we` out 1: update PC.
- `pc_src` out 2: 00 PC+4, 01 branch target, 10 jump target.
- `alu_src` out 1: 0 = rt register, 1 = immediate.
- `imm_zext` out 1: 1 = zero-extend immediate (andi/ori), 0 = sign-extend.
- `alu_func` out 6: ALU function code.
- `reg_we` out 1: register-file write.
- `reg_dst` out 1: 0 = rt, 1 = rd.
- `wb_sel` out 1: 0 = ALU result, 1 = memory data.
- `halted` out 1: FSM in HALT.
- `illegal` out 1: FSM in ERR.
- `instret` out 32: retired-instruction count, wraps at 2^32.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
- Decode uses `inst[31:26]`, with funct taken from `inst[5:0]`:
  - R-type (000000): alu_func=funct.
  - addi 001000: 100000.
  - andi 001100: 100100.
  - ori 001101: 100101.
  - slti 001010: 101010.
  - beq 000100 and bne 000101: 100010 (subtract).
  - lw 100011 and sw 101011: 100000.
  - j 000010: no ALU operation.
  - halt 111111.
  - Any other opcode is illegal.
- `alu_func` is a combinational function of `inst` and is valid in every state. It is 000000 for j, halt and illegal opcodes.
- FETCH:
  - Drives `mem_req`=1, `mem_sel`=0.
  - On `mem_ready`: pulses `ir_we`, and `pc_we` with `pc_src`=00, then goes to DECODE.
- DECODE:
  - halt goes to HALT.
  - An illegal opcode goes to ERR.
  - All other opcodes go to EXEC.
- EXEC:
  - `alu_src`=1 for I-type and lw/sw. `imm_zext`=1 only for andi/ori.
  - beq: `pc_we`=`alu_zero`, `pc_src`=01, then FETCH.
  - bne: `pc_we`=~`alu_zero`, `pc_src`=01, then FETCH.
  - j: `pc_we`=1, `pc_src`=10, then FETCH.
  - lw/sw go to MEM. R-type and arithmetic I-type go to WB.
- MEM:
  - Drives `mem_req`=1, `mem_sel`=1, `mem_we`=(sw).
  - On `mem_ready`: lw goes to WB, sw goes to FETCH.
- WB: `reg_we`=1 for one cycle. `reg_dst`=1 for R-type. `wb_sel`=1 for lw. Then FETCH.
- Retire:
  - `instret` increments by 1 on each transition into FETCH from EXEC, MEM or WB.
  - Halt and illegal instructions do not retire.
- Timeout:
  - A wait counter clears on entry to FETCH/MEM.
  - It increments each cycle in which `mem_req`=1 and `mem_ready`=0.
  - When it reaches `MEM_TIMEOUT` with `mem_ready` still 0, the next state is ERR.
- HALT and ERR are terminal until reset. In both, all enables and `mem_req` are 0.
- Every enable output (`mem_req`, `mem_we`, `ir_we`, `pc_we`, `reg_we`) is a Moore/Mealy function of the current state plus `mem_ready`/`alu_zero`. None are registered.

## Timing
- Reset:
  - State = FETCH, `instret`=0, wait counter=0.
  - `halted`=0, `illegal`=0.
  - `mem_req`=1 immediately after reset release, because FETCH drives it. All other enables are 0.
- Reset asserted mid-instruction aborts immediately. No partial write is committed after the asserting edge.
- With `mem_ready` high in the same cycle as `mem_req`:
  - R-type/I-type/sw take 4 cycles.
  - lw takes 5 cycles.
  - beq/bne/j take 3 cycles.
- Each wait cycle adds 1.
- `ir_we`/`pc_we` in FETCH occur only in the `mem_ready` cycle.
- `mem_ready` while `mem_req`=0 has no effect.
- `mem_ready` arriving in the same cycle the counter hits `MEM_TIMEOUT` counts as success; the FSM does not enter ERR.
- `instret` increments in the cycle after the retiring edge, i.e. registered.

## Test plan
- R-type add (`inst`=0x00221820), zero-wait memory -> `mem_req` in cycle 0. `reg_we`=1, `reg_dst`=1, `alu_func`=100000 in cycle 3. `instret`=1 in cycle 4.
- lw with `mem_ready` delayed 3 cycles in MEM -> `mem_sel`=1 held for 4 cycles. `reg_we`=1 with `wb_sel`=1 one cycle after `mem_ready`. Total latency 8 cycles.
- beq with `alu_zero`=1 -> `pc_we`=1, `pc_src`=01 in EXEC. Repeat with `alu_zero`=0 -> `pc_we`=0. Both retire (`instret`=2).
- `mem_ready` held 0 in FETCH with `MEM_TIMEOUT`=4 -> `illegal`=1 after 5 cycles, all enables 0. Opcode 010011 -> ERR from DECODE with no `reg_we`.
- halt opcode -> `halted`=1, `instret` unchanged. Deassert/reassert `rstn` in WB -> no `reg_we`, state FETCH, `instret`=0.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb sequencing,
// datapath enables, ALU function decode and retire counting.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] inst,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        alu_src,
  output logic        imm_zext,
  output logic [5:0]  alu_func,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        wb_sel,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, HALT, ERR
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t      state, state_next;
  logic [7:0]  wait_cnt;
  logic [5:0]  op, funct;
  logic [19:0] unused_bits;
  logic        is_r, is_addi, is_andi, is_ori, is_slti;
  logic        is_beq, is_bne, is_lw, is_sw, is_j, is_halt;
  logic        is_legal, is_imm, timeout, retire;

  assign op          = inst[31:26];
  assign funct       = inst[5:0];
  assign unused_bits = inst[25:6];

  assign is_r    = op == 6'b000000;
  assign is_addi = op == 6'b001000;
  assign is_andi = op == 6'b001100;
  assign is_ori  = op == 6'b001101;
  assign is_slti = op == 6'b001010;
  assign is_beq  = op == 6'b000100;
  assign is_bne  = op == 6'b000101;
  assign is_lw   = op == 6'b100011;
  assign is_sw   = op == 6'b101011;
  assign is_j    = op == 6'b000010;
  assign is_halt = op == 6'b111111;

  assign is_imm   = is_addi | is_andi | is_ori | is_slti;
  assign is_legal = is_r | is_imm | is_beq | is_bne
                  | is_lw | is_sw | is_j | is_halt;

  always_comb begin
    alu_func = 6'b000000;
    unique case (1'b1)
      is_r:                   alu_func = funct;
      is_addi, is_lw, is_sw:  alu_func = 6'b100000;
      is_andi:                alu_func = 6'b100100;
      is_ori:                 alu_func = 6'b100101;
      is_slti:                alu_func = 6'b101010;
      is_beq, is_bne:         alu_func = 6'b100010;
      default:                alu_func = 6'b000000;
    endcase
  end

  // A ready in the cycle the counter hits the limit still wins.
  assign timeout = (wait_cnt == TIMEOUT) && !mem_ready;

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_sel    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    alu_src    = 1'b0;
    imm_zext   = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    wb_sel     = 1'b0;
    unique case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = DECODE;
        end else if (timeout) begin
          state_next = ERR;
        end
      end
      DECODE: begin
        if (is_halt)        state_next = HALT;
        else if (!is_legal) state_next = ERR;
        else                state_next = EXEC;
      end
      EXEC: begin
        alu_src  = is_imm | is_lw | is_sw;
        imm_zext = is_andi | is_ori;
        if (is_beq || is_bne) begin
          pc_we      = is_beq ? alu_zero : !alu_zero;
          pc_src     = 2'b01;
          state_next = FETCH;
        end else if (is_j) begin
          pc_we      = 1'b1;
          pc_src     = 2'b10;
          state_next = FETCH;
        end else if (is_lw || is_sw) begin
          state_next = MEM;
        end else begin
          state_next = WB;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = is_sw;
        if (mem_ready)    state_next = is_lw ? WB : FETCH;
        else if (timeout) state_next = ERR;
      end
      WB: begin
        reg_we     = 1'b1;
        reg_dst    = is_r;
        wb_sel     = is_lw;
        state_next = FETCH;
      end
      HALT, ERR: state_next = state;
      default:   state_next = ERR;
    endcase
  end

  assign retire = (state_next == FETCH)
               && (state == EXEC || state == MEM || state == WB);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= FETCH;
      wait_cnt <= '0;
      instret  <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if (mem_req && !mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
      if (retire)
        instret <= instret + 32'd1;
    end
  end

  assign halted  = state == HALT;
  assign illegal = state == ERR;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] inst;
  logic        alu_zero, mem_ready;
  logic        mem_req, mem_we, mem_sel, ir_we, pc_we;
  logic [1:0]  pc_src;
  logic        alu_src, imm_zext, reg_we, reg_dst, wb_sel;
  logic        halted, illegal;
  logic [5:0]  alu_func;
  logic [31:0] instret;

  multicycle_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn), .inst(inst),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_src(alu_src), .imm_zext(imm_zext),
    .alu_func(alu_func), .reg_we(reg_we),
    .reg_dst(reg_dst), .wb_sel(wb_sel),
    .halted(halted), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  localparam logic [19:0] MREQ = 20'h80000;
  localparam logic [19:0] MWE  = 20'h40000;
  localparam logic [19:0] MSEL = 20'h20000;
  localparam logic [19:0] IRWE = 20'h10000;
  localparam logic [19:0] PCWE = 20'h08000;
  localparam logic [19:0] PCJ  = 20'h04000;
  localparam logic [19:0] PCB  = 20'h02000;
  localparam logic [19:0] ASRC = 20'h01000;
  localparam logic [19:0] ZEXT = 20'h00800;
  localparam logic [19:0] RWE  = 20'h00400;
  localparam logic [19:0] RDST = 20'h00200;
  localparam logic [19:0] WBS  = 20'h00100;
  localparam logic [19:0] HLT  = 20'h00080;
  localparam logic [19:0] ILL  = 20'h00040;
  localparam logic [19:0] FR   = MREQ | IRWE | PCWE;

  localparam logic [19:0] F_ADD = 20'h00020;
  localparam logic [19:0] F_SUB = 20'h00022;
  localparam logic [19:0] F_AND = 20'h00024;
  localparam logic [19:0] F_OR  = 20'h00025;
  localparam logic [19:0] F_SLT = 20'h0002A;

  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_ADDI = 32'h20220005;
  localparam logic [31:0] I_ANDI = 32'h3022000F;
  localparam logic [31:0] I_ORI  = 32'h3422000F;
  localparam logic [31:0] I_SLTI = 32'h28220007;
  localparam logic [31:0] I_LW   = 32'h8C220004;
  localparam logic [31:0] I_SW   = 32'hAC220004;
  localparam logic [31:0] I_BEQ  = 32'h10220003;
  localparam logic [31:0] I_BNE  = 32'h14220003;
  localparam logic [31:0] I_J    = 32'h08000010;
  localparam logic [31:0] I_HALT = 32'hFC000000;
  localparam logic [31:0] I_BAD  = 32'h4C000000;

  typedef struct {
    string       tag;
    logic [19:0] ctl;
    logic [31:0] ir;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [19:0] got;
      e   = q.pop_front();
      got = {mem_req, mem_we, mem_sel, ir_we, pc_we, pc_src,
             alu_src, imm_zext, reg_we, reg_dst, wb_sel,
             halted, illegal, alu_func};
      n_checks++;
      if (got !== e.ctl) begin
        n_fail++;
        $display("FAIL %s ctl got %05h want %05h",
                 e.tag, got, e.ctl);
      end
      n_checks++;
      if (instret !== e.ir) begin
        n_fail++;
        $display("FAIL %s instret got %0d want %0d",
                 e.tag, instret, e.ir);
      end
    end
  end

  task automatic step(input string t, input logic [31:0] i,
                      input logic rdy, input logic z,
                      input logic [19:0] ctl, input logic [31:0] ir);
    exp_t e;
    inst      = i;
    mem_ready = rdy;
    alu_zero  = z;
    e.tag = t;
    e.ctl = ctl;
    e.ir  = ir;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Four-cycle ALU instruction; ready in DECODE must be ignored.
  task automatic alu_op(input string t, input logic [31:0] i,
                        input logic [19:0] fn, input logic [19:0] ex,
                        input logic [19:0] wb, input logic [31:0] ir);
    step({t, "_f"}, i, 1'b1, 1'b0, FR | fn, ir);
    step({t, "_d"}, i, 1'b1, 1'b0, fn, ir);
    step({t, "_x"}, i, 1'b0, 1'b0, ex | fn, ir);
    step({t, "_w"}, i, 1'b0, 1'b0, wb | fn, ir);
  endtask

  task automatic branch(input string t, input logic [31:0] i,
                        input logic z, input logic [19:0] fn,
                        input logic [19:0] ex, input logic [31:0] ir);
    step({t, "_f"}, i, 1'b1, 1'b0, FR | fn, ir);
    step({t, "_d"}, i, 1'b0, z, fn, ir);
    step({t, "_x"}, i, 1'b0, z, ex | fn, ir);
  endtask

  task automatic pulse_reset(input string t);
    rstn = 1'b0;
    step(t, I_ADD, 1'b0, 1'b0, MREQ | F_ADD, 0);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; inst = I_ADD; mem_ready = 1'b0; alu_zero = 1'b0;
    @(posedge clk);
    #1;
    step("rst", I_ADD, 1'b0, 1'b0, MREQ | F_ADD, 0);
    rstn = 1'b1;

    alu_op("add",  I_ADD,  F_ADD, 0,           RWE | RDST, 0);
    alu_op("addi", I_ADDI, F_ADD, ASRC,        RWE,        1);
    alu_op("andi", I_ANDI, F_AND, ASRC | ZEXT, RWE,        2);
    alu_op("ori",  I_ORI,  F_OR,  ASRC | ZEXT, RWE,        3);
    alu_op("slti", I_SLTI, F_SLT, ASRC,        RWE,        4);

    step("lw_f", I_LW, 1'b1, 1'b0, FR | F_ADD, 5);
    step("lw_d", I_LW, 1'b0, 1'b0, F_ADD, 5);
    step("lw_x", I_LW, 1'b0, 1'b0, ASRC | F_ADD, 5);
    for (int k = 0; k < 3; k++)
      step("lw_mw", I_LW, 1'b0, 1'b0, MREQ | MSEL | F_ADD, 5);
    step("lw_mr", I_LW, 1'b1, 1'b0, MREQ | MSEL | F_ADD, 5);
    step("lw_w", I_LW, 1'b0, 1'b0, RWE | WBS | F_ADD, 5);

    step("sw_fw", I_SW, 1'b0, 1'b0, MREQ | F_ADD, 6);
    step("sw_f", I_SW, 1'b1, 1'b0, FR | F_ADD, 6);
    step("sw_d", I_SW, 1'b0, 1'b0, F_ADD, 6);
    step("sw_x", I_SW, 1'b0, 1'b0, ASRC | F_ADD, 6);
    step("sw_m", I_SW, 1'b1, 1'b0, MREQ | MWE | MSEL | F_ADD, 6);

    branch("beq1", I_BEQ, 1'b1, F_SUB, PCWE | PCB, 7);
    branch("beq0", I_BEQ, 1'b0, F_SUB, PCB,        8);
    branch("bne0", I_BNE, 1'b0, F_SUB, PCWE | PCB, 9);
    branch("bne1", I_BNE, 1'b1, F_SUB, PCB,        10);
    branch("j",    I_J,   1'b0, 0,     PCWE | PCJ, 11);

    step("lwb_f", I_LW, 1'b1, 1'b0, FR | F_ADD, 12);
    step("lwb_d", I_LW, 1'b0, 1'b0, F_ADD, 12);
    step("lwb_x", I_LW, 1'b0, 1'b0, ASRC | F_ADD, 12);
    for (int k = 0; k < 4; k++)
      step("lwb_mw", I_LW, 1'b0, 1'b0, MREQ | MSEL | F_ADD, 12);
    step("lwb_mr", I_LW, 1'b1, 1'b0, MREQ | MSEL | F_ADD, 12);
    step("lwb_w", I_LW, 1'b0, 1'b0, RWE | WBS | F_ADD, 12);

    step("halt_f", I_HALT, 1'b1, 1'b0, FR, 13);
    step("halt_d", I_HALT, 1'b1, 1'b0, 0, 13);
    step("halt_h0", I_HALT, 1'b1, 1'b0, HLT, 13);
    step("halt_h1", I_HALT, 1'b1, 1'b0, HLT, 13);

    pulse_reset("rst2");
    for (int k = 0; k < 5; k++)
      step("to_fw", I_ADD, 1'b0, 1'b0, MREQ | F_ADD, 0);
    step("to_err0", I_ADD, 1'b0, 1'b0, ILL | F_ADD, 0);
    step("to_err1", I_ADD, 1'b1, 1'b0, ILL | F_ADD, 0);

    pulse_reset("rst3");
    step("bad_f", I_BAD, 1'b1, 1'b0, FR, 0);
    step("bad_d", I_BAD, 1'b0, 1'b0, 0, 0);
    step("bad_e0", I_BAD, 1'b0, 1'b0, ILL, 0);
    step("bad_e1", I_BAD, 1'b1, 1'b0, ILL, 0);

    pulse_reset("rst4");
    alu_op("add2", I_ADD, F_ADD, 0, RWE | RDST, 0);
    step("add3_f", I_ADD, 1'b1, 1'b0, FR | F_ADD, 1);
    step("add3_d", I_ADD, 1'b0, 1'b0, F_ADD, 1);
    step("add3_x", I_ADD, 1'b0, 1'b0, F_ADD, 1);
    rstn = 1'b0;
    step("add3_wrst", I_ADD, 1'b0, 1'b0, MREQ | F_ADD, 0);
    rstn = 1'b1;
    alu_op("add4", I_ADD, F_ADD, 0, RWE | RDST, 0);
    step("end_f", I_ADD, 1'b0, 1'b0, MREQ | F_ADD, 1);

    repeat (2) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain left %0d want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
